ps2_kbd_rx: RTL and testbench

Parametrised PS/2 keyboard receiver running on the system clock. It oversamples ps2_clk/ps2_data and validates each 11-bit frame (start, odd parity, stop). Scan-code bytes are decoded into make/break events with an extended-key flag and buffered in an event FIFO with a valid/ready interface. It replaces ad-hoc ps2_clk-clocked capture logic and feeds display or console consumers, which format events separately.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_evt_fifo.sv | 60 ++++++
 rtl/ps2_kbd_rx.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Covers scan-code prefixes, the event record, the decoder states and the frame check.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_dec_state_e;

  // head = {parity, data[7:0], start} as shifted in LSB-first; stop is the live 11th bit
  function automatic logic ps2_frame_ok(input logic [9:0] head, input logic stop_bit);
    return (head[0] == 1'b0) && ((^head[9:1]) == 1'b1) && (stop_bit == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO for decoded key events.
// It accepts a push into a full FIFO only when a pop happens in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  ps2_evt_t               wr_data_i,
  input  logic                   pop_i,
  output ps2_evt_t               rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push_s;
  logic            do_pop_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign level_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver on the system clock.
// Contains sync, frame capture, watchdog, E0/F0 decoder, repeat filter and event FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_W           = 8,
  parameter int TIMEOUT_CYC     = 100000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_break,
  output logic                          evt_ext,
  output logic [CNT_W-1:0]              press_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          timeout_err,
  input  logic                          clr_status
);

  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  logic            clk_meta_q, clk_sync_q, clk_hist_q;
  logic            data_meta_q, data_sync_q;
  logic            fall_s;
  logic [9:0]      shift_q;
  logic [3:0]      bit_cnt_q;
  logic [WD_W-1:0] wd_q;
  logic            byte_strobe_q, parity_err_q, timeout_err_q;
  logic [7:0]      byte_q;

  ps2_dec_state_e  state_q, state_d;
  ps2_evt_t        evt_s, head_s;
  logic            emit_s, key_match_s, drop_s, push_s, accept_s, pop_s;
  logic            fifo_full_s, fifo_empty_s;
  logic            lm_valid_q;
  logic [8:0]      lm_key_q;
  logic [CNT_W-1:0] press_count_q;
  logic            overflow_q;

  assign fall_s = clk_hist_q && !clk_sync_q;

  // Two-flop synchronisers, idle-high, plus clock history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_hist_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_hist_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Frame capture, frame check on the 11th edge, and partial-frame watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q       <= '0;
      bit_cnt_q     <= 4'd0;
      wd_q          <= '0;
      byte_strobe_q <= 1'b0;
      parity_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      byte_q        <= 8'h00;
    end else begin
      byte_strobe_q <= 1'b0;
      parity_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      if (fall_s) begin
        wd_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= 4'd0;
          if (ps2_frame_ok(shift_q, data_sync_q)) begin
            byte_strobe_q <= 1'b1;
            byte_q        <= shift_q[8:1];
          end else begin
            parity_err_q <= 1'b1;
          end
        end else begin
          shift_q   <= {data_sync_q, shift_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          bit_cnt_q     <= 4'd0;
          wd_q          <= '0;
          timeout_err_q <= 1'b1;
        end else begin
          wd_q <= wd_q + WD_W'(1);
        end
      end else begin
        wd_q <= '0;
      end
    end
  end

  // Decoder state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prefix decoding; a bad frame also discards any pending prefix
  always_comb begin
    state_d    = state_q;
    emit_s     = 1'b0;
    evt_s.ext  = (state_q == EXT) || (state_q == EXT_BRK);
    evt_s.brk  = (state_q == BRK) || (state_q == EXT_BRK);
    evt_s.code = byte_q;
    if (parity_err_q) begin
      state_d = IDLE;
    end else if (byte_strobe_q) begin
      case (byte_q)
        PS2_EXT: begin
          if (state_q == IDLE) begin
            state_d = EXT;
          end else begin
            state_d = state_q;
          end
        end
        PS2_BRK: begin
          case (state_q)
            IDLE:    state_d = BRK;
            EXT:     state_d = EXT_BRK;
            default: state_d = state_q;
          endcase
        end
        default: begin
          emit_s  = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign key_match_s = lm_valid_q && (lm_key_q == {evt_s.ext, evt_s.code});
  assign drop_s      = (SUPPRESS_REPEAT != 0) && emit_s && !evt_s.brk && key_match_s;
  assign push_s      = emit_s && !drop_s;
  assign pop_s       = evt_valid && evt_ready;
  assign accept_s    = push_s && (!fifo_full_s || pop_s);

  // Repeat filter memory, press counter and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lm_valid_q    <= 1'b0;
      lm_key_q      <= 9'd0;
      press_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      if (emit_s && !evt_s.brk && !drop_s) begin
        lm_valid_q <= 1'b1;
        lm_key_q   <= {evt_s.ext, evt_s.code};
      end else if (emit_s && evt_s.brk && key_match_s) begin
        lm_valid_q <= 1'b0;
      end
      if (accept_s && !evt_s.brk) begin
        press_count_q <= press_count_q + CNT_W'(1);
      end
      if (push_s && !accept_s) begin
        overflow_q <= 1'b1;
      end else if (clr_status) begin
        overflow_q <= 1'b0;
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .push_i    (accept_s),
    .wr_data_i (evt_s),
    .pop_i     (pop_s),
    .rd_data_o (head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .level_o   (fifo_level)
  );

  assign evt_valid   = !fifo_empty_s;
  assign evt_code    = head_s.code;
  assign evt_break   = head_s.brk;
  assign evt_ext     = head_s.ext;
  assign press_count = press_count_q;
  assign overflow    = overflow_q;
  assign parity_err  = parity_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: a filtering instance plus a non-filtering
// instance driven by the same PS/2 lines.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data, evt_ready, clr_status;

  logic       evt_valid, evt_break, evt_ext, overflow, parity_err, timeout_err;
  logic [7:0] evt_code, press_count;
  logic [3:0] fifo_level;

  logic       v1, b1, x1, ov1, pe1, te1;
  logic [7:0] c1, pc1;
  logic [3:0] lv1;

  int n_checks = 0;
  int n_errs   = 0;
  int n_par, n_to, n_ev1;
  logic [9:0] exp_q[$];
  time last_fall_t, valid_rise_t;
  logic valid_prev;

  always #5 clk = ~clk;

  ps2_kbd_rx #(.FIFO_DEPTH(8), .CNT_W(8), .TIMEOUT_CYC(TO), .SUPPRESS_REPEAT(1)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_break(evt_break), .evt_ext(evt_ext), .press_count(press_count),
    .fifo_level(fifo_level), .overflow(overflow), .parity_err(parity_err),
    .timeout_err(timeout_err), .clr_status(clr_status));

  ps2_kbd_rx #(.FIFO_DEPTH(8), .CNT_W(8), .TIMEOUT_CYC(TO), .SUPPRESS_REPEAT(0)) dut_nf (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(v1), .evt_ready(1'b1), .evt_code(c1),
    .evt_break(b1), .evt_ext(x1), .press_count(pc1),
    .fifo_level(lv1), .overflow(ov1), .parity_err(pe1),
    .timeout_err(te1), .clr_status(clr_status));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (7) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall_t = $time;
      repeat (15) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (8) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    clr_status = 1'b0;
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_par = 0;
    n_to = 0;
    n_ev1 = 0;
    valid_rise_t = 0;
    exp_q.delete();
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check_eq(tag, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on each handshake and counts error pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (parity_err) n_par++;
      if (timeout_err) n_to++;
      if (v1) n_ev1++;
      if (evt_valid && !valid_prev) valid_rise_t = $time;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check_eq("evt_unexpected", exp_q.size(), 1);
        else check_eq("evt", {evt_ext, evt_break, evt_code}, exp_q.pop_front());
      end
    end
    valid_prev = evt_valid;
  end

  initial begin
    valid_prev = 1'b0;
    last_fall_t = 0;
    do_reset();
    check_eq("rst_valid", evt_valid, 0);
    check_eq("rst_count", press_count, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_status", {overflow, parity_err, timeout_err}, 0);

    // single make and latency
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 11);
    check_eq("lat_le4", (valid_rise_t > last_fall_t) && (valid_rise_t - last_fall_t <= 40), 1);
    wait_drain("drain_single");
    check_eq("count_single", press_count, 1);

    // typematic repeat then release
    do_reset();
    expect_evt(1'b0, 1'b0, 8'h1C);
    expect_evt(1'b0, 1'b1, 8'h1C);
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    wait_drain("drain_typematic");
    check_eq("count_typematic", press_count, 1);
    check_eq("nf_events", n_ev1, 4);
    check_eq("nf_count", pc1, 3);

    // extended make and break
    do_reset();
    expect_evt(1'b1, 1'b0, 8'h75);
    expect_evt(1'b1, 1'b1, 8'h75);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    wait_drain("drain_ext");
    check_eq("count_ext", press_count, 1);

    // bad parity frame is discarded
    do_reset();
    expect_evt(1'b0, 1'b0, 8'h32);
    send_frame(8'h1C, 1'b1, 11);
    send_frame(8'h32, 1'b0, 11);
    wait_drain("drain_parity");
    check_eq("parity_pulses", n_par, 1);
    check_eq("count_parity", press_count, 1);

    // partial frame aborted by the watchdog
    do_reset();
    expect_evt(1'b0, 1'b0, 8'h24);
    send_frame(8'h24, 1'b0, 5);
    repeat (TO + 10) @(negedge clk);
    send_frame(8'h24, 1'b0, 11);
    wait_drain("drain_timeout");
    check_eq("timeout_pulses", n_to, 1);

    // overflow with consumer stalled
    do_reset();
    evt_ready = 1'b0;
    begin
      logic [7:0] codes [9];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
      for (int i = 0; i < 9; i++) begin
        if (i < 8) expect_evt(1'b0, 1'b0, codes[i]);
        send_frame(codes[i], 1'b0, 11);
      end
    end
    check_eq("ovf_level", fifo_level, 8);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_count", press_count, 8);
    evt_ready = 1'b1;
    wait_drain("drain_ovf");
    check_eq("ovf_sticky", overflow, 1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
    check_eq("ovf_cleared", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
